// File: rtl/mem_port_master_if.sv
// Request/response handshake and memory data-port signals for mem_port_master.
// The master modport is the block's view; slave is the CPU/memory environment's view.
interface mem_port_master_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int OFF_W  = 9
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_base;
    logic [OFF_W-1:0]  req_offset;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;
    logic [ADDR_W-1:0] address_bus;
    logic [DATA_W-1:0] data_bus;
    logic [DATA_W-1:0] incoming_data_bus;
    logic              write_mode;
    logic              doubleRead;
    logic              doubleWrite;

    modport master (
        input  req_valid, req_op, req_base, req_offset, req_wdata, rsp_ready, data_bus,
        output req_ready, rsp_valid, rsp_rdata, busy, address_bus, incoming_data_bus,
               write_mode, doubleRead, doubleWrite
    );

    modport slave (
        output req_valid, req_op, req_base, req_offset, req_wdata, rsp_ready, data_bus,
        input  req_ready, rsp_valid, rsp_rdata, busy, address_bus, incoming_data_bus,
               write_mode, doubleRead, doubleWrite
    );
endinterface

// File: rtl/mem_port_master.sv
// CPU-side load/store initiator for the memory data port: one request at a time,
// byte address = base + 2*offset, fully registered bus and response outputs.
module mem_port_master #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 16,
    parameter int OFF_W    = 9,
    parameter int WAIT_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_port_master_if.master    port,
    output logic [1:0]           dbg_state
);
    // Handshakes: a request transfers on a clock edge with req_valid & req_ready;
    // a response transfers on a clock edge with rsp_valid & rsp_ready.
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam int CNT_W = (WAIT_CYC < 2) ? 1 : $clog2(WAIT_CYC + 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              store_q, store_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] inc_q, inc_d;
    logic              wm_q, wm_d;
    logic              dr_q, dr_d;
    logic              dw_q, dw_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        store_d     = store_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        busy_d      = busy_q;
        addr_d      = addr_q;
        inc_d       = inc_q;
        wm_d        = wm_q;
        dr_d        = dr_q;
        dw_d        = dw_q;
        case (state_q)
            IDLE: begin
                if (port.req_valid) begin
                    state_d     = SETUP;
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    // Offset is in words; the add wraps within the address space.
                    addr_d      = port.req_base + ADDR_W'({port.req_offset, 1'b0});
                    dr_d        = (port.req_op == 2'b01);
                    dw_d        = (port.req_op == 2'b11);
                    inc_d       = port.req_op[1] ? port.req_wdata : '0;
                    store_d     = port.req_op[1];
                    cnt_d       = CNT_W'(WAIT_CYC);
                end
            end
            SETUP: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    if (store_q) begin
                        wm_d    = 1'b1;
                        state_d = WRITE;
                    end else begin
                        rsp_rdata_d = port.data_bus;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end
                end
            end
            WRITE: begin
                // Memory commits on this edge; strobe lasts exactly one cycle.
                wm_d        = 1'b0;
                rsp_rdata_d = '0;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (port.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    req_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    addr_d      = '0;
                    inc_d       = '0;
                    dr_d        = 1'b0;
                    dw_d        = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            store_q     <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            busy_q      <= 1'b0;
            addr_q      <= '0;
            inc_q       <= '0;
            wm_q        <= 1'b0;
            dr_q        <= 1'b0;
            dw_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            store_q     <= store_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            busy_q      <= busy_d;
            addr_q      <= addr_d;
            inc_q       <= inc_d;
            wm_q        <= wm_d;
            dr_q        <= dr_d;
            dw_q        <= dw_d;
        end
    end

    assign port.req_ready         = req_ready_q;
    assign port.rsp_valid         = rsp_valid_q;
    assign port.rsp_rdata         = rsp_rdata_q;
    assign port.busy              = busy_q;
    assign port.address_bus       = addr_q;
    assign port.incoming_data_bus = inc_q;
    assign port.write_mode        = wm_q;
    assign port.doubleRead        = dr_q;
    assign port.doubleWrite       = dw_q;
    assign dbg_state              = state_q;
endmodule

// File: tb/tb_mem_port_master.sv
// Bench for mem_port_master: behavioural 4x1KB memory, table of load/store vectors,
// scoreboard of expected response data, plus back-pressure and mid-write reset sequences.
module tb_mem_port_master;
    logic clk;
    logic rst_n;
    logic [1:0] dbg_state;

    mem_port_master_if #(.ADDR_W(12), .DATA_W(16), .OFF_W(9)) bus ();

    mem_port_master #(.ADDR_W(12), .DATA_W(16), .OFF_W(9), .WAIT_CYC(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .port      (bus.master),
        .dbg_state (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory: 2048 words, word index = byte address [11:1]; double modes follow a stored pointer.
    logic [15:0] mem [0:2047];
    logic [10:0] widx;
    logic [15:0] ptr;
    always_comb begin
        widx = bus.address_bus[11:1];
        ptr  = mem[widx];
        bus.data_bus = bus.doubleRead ? mem[ptr[11:1]] : mem[widx];
    end
    always @(posedge clk) begin
        if (bus.write_mode) begin
            if (bus.doubleWrite) mem[ptr[11:1]] <= bus.incoming_data_bus;
            else                 mem[widx]      <= bus.incoming_data_bus;
        end
    end

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [11:0] base;
        logic [8:0]  off;
        logic [15:0] wdata;
        logic [11:0] exp_addr;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    task automatic run_req(input vec_t v);
        int lat;
        int wm_cnt;
        bit seen;
        logic [15:0] e;
        @(negedge clk);
        check("req_ready_idle", bus.req_ready, 1);
        bus.req_valid  = 1'b1;
        bus.req_op     = v.op;
        bus.req_base   = v.base;
        bus.req_offset = v.off;
        bus.req_wdata  = v.wdata;
        exp_q.push_back(v.exp_rdata);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("address_bus", bus.address_bus, v.exp_addr);
        check("doubleRead", bus.doubleRead, v.op == 2'b01);
        check("doubleWrite", bus.doubleWrite, v.op == 2'b11);
        check("busy", bus.busy, 1);
        check("req_ready_busy", bus.req_ready, 0);
        lat = 0; wm_cnt = 0; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.rsp_valid) seen = 1;
            else begin
                if (bus.write_mode) begin
                    wm_cnt++;
                    check("doubleWrite_in_write", bus.doubleWrite, v.op == 2'b11);
                end
                @(posedge clk); #1;
                lat++;
            end
        end
        check("rsp_seen", seen, 1);
        check("latency", lat, v.op[1] ? 2 : 1);
        check("write_mode_cycles", wm_cnt, v.op[1] ? 1 : 0);
        check("write_mode_in_resp", bus.write_mode, 0);
        e = exp_q.pop_front();
        check("rsp_rdata", bus.rsp_rdata, e);
        @(posedge clk); #1;
        check("rsp_valid_done", bus.rsp_valid, 0);
        check("idle_address", bus.address_bus, 0);
        check("idle_state", dbg_state, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic [15:0] held;
        bit seen;
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        mem[(12'h412 - 12'h400) / 2 + 512] = 16'h0018;
        mem[512 + 48]  = 16'h07FE;
        mem[512 + 511] = 16'hBBBB;
        mem[512 + 49]  = 16'h07FF;

        vecs[0] = '{2'b00, 12'h400, 9'd9,   16'h0000, 12'h412, 16'h0018};
        vecs[1] = '{2'b01, 12'h400, 9'd48,  16'h0000, 12'h460, 16'hBBBB};
        vecs[2] = '{2'b11, 12'h400, 9'd49,  16'h1234, 12'h462, 16'h0000};
        vecs[3] = '{2'b00, 12'h400, 9'd511, 16'h0000, 12'h7FE, 16'h1234};
        vecs[4] = '{2'b10, 12'hFFE, 9'd2,   16'hA5A5, 12'h002, 16'h0000};
        vecs[5] = '{2'b00, 12'h000, 9'd1,   16'h0000, 12'h002, 16'hA5A5};
        vecs[6] = '{2'b10, 12'h800, 9'd511, 16'h5A5A, 12'hBFE, 16'h0000};
        vecs[7] = '{2'b00, 12'hBFE, 9'd0,   16'h0000, 12'hBFE, 16'h5A5A};

        bus.req_valid = 0; bus.req_op = 0; bus.req_base = 0; bus.req_offset = 0;
        bus.req_wdata = 0; bus.rsp_ready = 1;
        rst_n = 0;
        #12;
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_address", bus.address_bus, 0);
        check("rst_write_mode", bus.write_mode, 0);
        @(negedge clk); rst_n = 1;

        for (int i = 0; i < 8; i++) run_req(vecs[i]);
        check("mem_data_instruction_1", mem[1], 16'hA5A5);

        for (int i = 0; i < 4; i++) begin
            v.op = 2'b10;
            v.base = 12'($urandom_range(0, 4095)) & 12'hFFE;
            v.off = 9'($urandom_range(0, 511));
            v.wdata = 16'($urandom_range(0, 65535));
            v.exp_addr = 12'((32'(v.base) + 2 * 32'(v.off)) % 4096);
            v.exp_rdata = 16'h0000;
            run_req(v);
            v.op = 2'b00;
            v.exp_rdata = v.wdata;
            run_req(v);
        end

        // Back-pressure: response must hold while req_valid pulses.
        bus.rsp_ready = 0;
        @(negedge clk);
        bus.req_valid = 1; bus.req_op = 2'b00; bus.req_base = 12'h400; bus.req_offset = 9'd9;
        exp_q.push_back(16'h0018);
        @(posedge clk); #1;
        bus.req_valid = 0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.rsp_valid) seen = 1;
            else begin @(posedge clk); #1; end
        end
        check("bp_rsp_seen", seen, 1);
        held = exp_q[0];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.req_valid = (i % 2 == 0);
            bus.req_op = 2'b10; bus.req_base = 12'h100; bus.req_wdata = 16'hFFFF;
            @(posedge clk); #1;
            check("bp_rsp_valid", bus.rsp_valid, 1);
            check("bp_rsp_rdata", bus.rsp_rdata, held);
            check("bp_req_ready", bus.req_ready, 0);
            check("bp_address", bus.address_bus, 12'h412);
            check("bp_write_mode", bus.write_mode, 0);
        end
        @(negedge clk);
        bus.req_valid = 0; bus.rsp_ready = 1;
        check("bp_rsp_final", bus.rsp_rdata, exp_q.pop_front());
        @(posedge clk); #1;
        check("bp_done_valid", bus.rsp_valid, 0);
        check("bp_done_ready", bus.req_ready, 1);
        check("bp_no_store", mem[(12'h100 >> 1)], 16'h0000);

        // Reset while the write strobe is high: nothing may commit.
        @(negedge clk);
        bus.req_valid = 1; bus.req_op = 2'b10; bus.req_base = 12'h000; bus.req_offset = 9'd10;
        bus.req_wdata = 16'hDEAD;
        @(posedge clk); #1;
        bus.req_valid = 0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.write_mode) seen = 1;
            else begin @(posedge clk); #1; end
        end
        check("rw_write_seen", seen, 1);
        #1 rst_n = 0;
        #1;
        check("rw_write_mode", bus.write_mode, 0);
        check("rw_req_ready", bus.req_ready, 1);
        check("rw_address", bus.address_bus, 0);
        check("rw_incoming", bus.incoming_data_bus, 0);
        check("rw_busy", bus.busy, 0);
        @(posedge clk);
        @(negedge clk); rst_n = 1;
        check("rw_no_commit", mem[10], 16'h0000);
        v = '{2'b00, 12'h000, 9'd10, 16'h0000, 12'h014, 16'h0000};
        run_req(v);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
